sumres3_sched: RTL

Round-robin scheduler that shares one `sumres3` three-operand add/subtract datapath among `N_REQ` requesters. Each requester presents operands `a`, `b`, `c` and a `sub` flag over a valid/ready handshake. The scheduler grants one request at a time, registers the operands into the datapath, captures `S1`/`S2`/`Cout`, and returns them with the requester ID over a response handshake. It sits between the client blocks and the single `sumres3` instance.

---
 rtl/sumres3_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sumres3.sv | 25 ++
 rtl/sumres3_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sumres3_pkg.sv
// Shared types and widths for the sumres3 scheduler slice.
package sumres3_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned RES_W  = 6;
  localparam int unsigned COUT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_onehot_o,
  output logic [ID_W-1:0]  gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    // Upper half of the ring first, then the wrapped lower half.
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found           = 1'b1;
        gnt_onehot_o[i] = 1'b1;
        gnt_idx_o       = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req_i[i]) begin
        found           = 1'b1;
        gnt_onehot_o[i] = 1'b1;
        gnt_idx_o       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sumres3.sv
// Three-operand add/subtract datapath: S1 = a +/- b, S2 = S1 +/- c, all mod 2^RES_W.
module sumres3
  import sumres3_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic [OP_W-1:0]   c_i,
  input  logic              sub_i,
  output logic [RES_W-1:0]  s1_o,
  output logic [RES_W-1:0]  s2_o,
  output logic [COUT_W-1:0] cout_o
);

  logic [RES_W-1:0] a_ext, b_ext, c_ext;

  always_comb begin
    a_ext  = {{(RES_W - OP_W){1'b0}}, a_i};
    b_ext  = {{(RES_W - OP_W){1'b0}}, b_i};
    c_ext  = {{(RES_W - OP_W){1'b0}}, c_i};
    s1_o   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    s2_o   = sub_i ? (s1_o - c_ext) : (s1_o + c_ext);
    cout_o = s2_o[RES_W-1 -: COUT_W];
  end

endmodule

// File: rtl/sumres3_sched.sv
// Round-robin scheduler sharing one sumres3 datapath among N_REQ requesters.
module sumres3_sched
  import sumres3_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  input  logic [OP_W*N_REQ-1:0]   req_c,
  input  logic [N_REQ-1:0]        req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_s1,
  output logic [RES_W-1:0]        rsp_s2,
  output logic [COUT_W-1:0]       rsp_cout
);

  sched_state_t      state_q;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_idx;
  logic [N_REQ-1:0]  gnt_onehot;
  logic [OP_W-1:0]   a_q, b_q, c_q;
  logic [OP_W-1:0]   sel_a, sel_b, sel_c;
  logic              sub_q, sel_sub;
  logic [RES_W-1:0]  s1, s2;
  logic [COUT_W-1:0] cout;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [RES_W-1:0]  rsp_s1_q, rsp_s2_q;
  logic [COUT_W-1:0] rsp_cout_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i        (req_valid),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx)
  );

  sumres3 u_dp (
    .a_i    (a_q),
    .b_i    (b_q),
    .c_i    (c_q),
    .sub_i  (sub_q),
    .s1_o   (s1),
    .s2_o   (s2),
    .cout_o (cout)
  );

  always_comb begin
    sel_a   = req_a[int'(gnt_idx)*OP_W +: OP_W];
    sel_b   = req_b[int'(gnt_idx)*OP_W +: OP_W];
    sel_c   = req_c[int'(gnt_idx)*OP_W +: OP_W];
    sel_sub = req_sub[gnt_idx];
    if (gnt_q == ID_W'(N_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = gnt_q + ID_W'(1);
    end
  end

  // Gated by rst_n so no accept is advertised while reset is held.
  assign req_ready = (rst_n && (state_q == StIdle)) ? gnt_onehot : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s1    = rsp_s1_q;
  assign rsp_s2    = rsp_s2_q;
  assign rsp_cout  = rsp_cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s1_q    <= '0;
      rsp_s2_q    <= '0;
      rsp_cout_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            c_q     <= sel_c;
            sub_q   <= sel_sub;
            gnt_q   <= gnt_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_s1_q    <= s1;
          rsp_s2_q    <= s2;
          rsp_cout_q  <= cout;
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
